// File: rtl/fifo_hs_sync.sv
// ============================================================================
// Module      : fifo_hs_sync
// Description : Single-clock synchronous FIFO with req/ack handshakes on both
//               sides, occupancy level, programmable almost-full/almost-empty
//               flags, synchronous flush and a sticky overflow-attempt flag.
//
// Ports       : clk          - clock, all logic on rising edge
//               rstn         - asynchronous active-low reset
//               wr_data      - write data (dw bits)
//               wr_req       - writer offers wr_data
//               wr_ack       - FIFO can accept (== !full)
//               rd_data      - head-of-queue data, show-ahead
//               rd_req       - head valid (== !empty)
//               rd_ack       - reader takes head
//               flush        - synchronous clear of both pointers
//               level        - occupancy 0..depth
//               almost_full  - level >= af_thr
//               almost_empty - level <= ae_thr
//               ovf          - sticky: wr_req seen while full
//               ovf_clr      - clears ovf (a same-cycle set wins)
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_hs_sync #(
    parameter int dw     = 8,
    parameter int depth  = 16,
    parameter int af_thr = depth - 2,
    parameter int ae_thr = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [dw-1:0]          wr_data,
    input  logic                   wr_req,
    output logic                   wr_ack,
    output logic [dw-1:0]          rd_data,
    output logic                   rd_req,
    input  logic                   rd_ack,
    input  logic                   flush,
    output logic [$clog2(depth):0] level,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int aw = $clog2(depth);

    localparam logic [aw:0] c_one    = (aw+1)'(1);
    localparam logic [aw:0] c_af_thr = (aw+1)'(af_thr);
    localparam logic [aw:0] c_ae_thr = (aw+1)'(ae_thr);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [dw-1:0] mem_q [depth];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate counter.
    logic [aw:0] wr_ptr_q, wr_ptr_d;
    logic [aw:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q,    ovf_d;

    logic        full;
    logic        empty;
    logic        wr_xfer;
    logic        rd_xfer;

    // ------------------------------------------------------------------------
    // Status, derived only from registered pointers
    // ------------------------------------------------------------------------
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]) &&
                (wr_ptr_q[aw]     != rd_ptr_q[aw]);
    end

    assign wr_ack       = !full;
    assign rd_req       = !empty;
    assign level        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (level >= c_af_thr);
    assign almost_empty = (level <= c_ae_thr);
    assign ovf          = ovf_q;

    // Show-ahead read of the head entry.
    assign rd_data      = mem_q[rd_ptr_q[aw-1:0]];

    assign wr_xfer      = wr_req && !full;
    assign rd_xfer      = rd_ack && !empty;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (flush) begin
            // Flush discards any transfer offered in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_xfer) begin
                wr_ptr_d = wr_ptr_q + c_one;
            end
            if (rd_xfer) begin
                rd_ptr_d = rd_ptr_q + c_one;
            end
        end
    end

    // Set has priority over clear; flush leaves the flag alone.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_req && full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array is not reset; a write discarded by flush is not stored.
    always_ff @(posedge clk) begin
        if (wr_xfer && !flush) begin
            mem_q[wr_ptr_q[aw-1:0]] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_hs_sync.sv
// ============================================================================
// Module      : tb_fifo_hs_sync
// Description : Self-checking bench for fifo_hs_sync (dw=8, depth=16,
//               af_thr=14, ae_thr=2). A queue-based reference model is
//               compared against the DUT every cycle, and directed scenarios
//               carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_hs_sync;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic           clk     = 1'b0;
    logic           rstn    = 1'b1;
    logic [DW-1:0]  wr_data = '0;
    logic           wr_req  = 1'b0;
    logic           wr_ack;
    logic [DW-1:0]  rd_data;
    logic           rd_req;
    logic           rd_ack  = 1'b0;
    logic           flush   = 1'b0;
    logic [4:0]     level;
    logic           almost_full;
    logic           almost_empty;
    logic           ovf;
    logic           ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_hs_sync #(
        .dw     (DW),
        .depth  (DEPTH),
        .af_thr (AF),
        .ae_thr (AE)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_data      (wr_data),
        .wr_req       (wr_req),
        .wr_ack       (wr_ack),
        .rd_data      (rd_data),
        .rd_req       (rd_req),
        .rd_ack       (rd_ack),
        .flush        (flush),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: a plain queue of accepted words plus the sticky flag.
    // ------------------------------------------------------------------------
    logic [DW-1:0] m_q[$];
    logic          m_ovf = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            m_ovf <= 1'b0;
        end else begin
            automatic int  sz = m_q.size();
            automatic bit  wx = wr_req && (sz < DEPTH);
            automatic bit  rx = rd_ack && (sz > 0);
            if (wr_req && sz == DEPTH)
                m_ovf <= 1'b1;
            else if (ovf_clr)
                m_ovf <= 1'b0;
            if (flush) begin
                m_q.delete();
            end else begin
                if (rx) void'(m_q.pop_front());
                if (wx) m_q.push_back(wr_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        automatic int sz = m_q.size();
        chk("m_level",  32'(level),        32'(sz));
        chk("m_wr_ack", 32'(wr_ack),       32'(sz < DEPTH));
        chk("m_rd_req", 32'(rd_req),       32'(sz > 0));
        chk("m_af",     32'(almost_full),  32'(sz >= AF));
        chk("m_ae",     32'(almost_empty), 32'(sz <= AE));
        chk("m_ovf",    32'(ovf),          32'(m_ovf));
        if (sz > 0)
            chk("m_rd_data", 32'(rd_data), 32'(m_q[0]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] v;
        // ---------------- Reset ----------------
        #2 rstn = 1'b0;
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_wr_ack", 32'(wr_ack), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // ---------------- 1: fill 0x01..0x10 ----------------
        wr_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wr_data = DW'(i);
            tick();
            chk("fill_level", 32'(level), 32'(i));
            chk("fill_af", 32'(almost_full), 32'(i >= 14));
            chk("fill_wr_ack", 32'(wr_ack), 32'(i < 16));
        end
        wr_data = 8'hEE;      // 17th request while full
        chk("ovf_before", 32'(ovf), 0);
        tick();
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_level", 32'(level), 16);
        wr_req = 1'b0;

        // ---------------- 2: drain ----------------
        rd_ack = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", 32'(rd_data), 32'(i));
            tick();
            chk("drain_level", 32'(level), 32'(16 - i));
            chk("drain_ae", 32'(almost_empty), 32'((16 - i) <= 2));
        end
        chk("drain_rd_req", 32'(rd_req), 0);
        rd_ack  = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);

        // ---------------- 3: streaming at level 5 ----------------
        wr_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = DW'(100 + i);
            tick();
        end
        chk("stream_pre_level", 32'(level), 5);
        chk("stream_head", 32'(rd_data), 100);
        rd_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_data = DW'(105 + i);
            tick();
            chk("stream_level", 32'(level), 5);
        end
        chk("stream_tail_head", 32'(rd_data), 200);
        wr_req = 1'b0;
        rd_ack = 1'b0;

        // ---------------- 4: full with simultaneous read ----------------
        wr_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wr_data = DW'(8'h30 + i);
            tick();
        end
        chk("full_level", 32'(level), 16);
        wr_data = 8'hAA;
        rd_ack  = 1'b1;
        tick();
        chk("full_rw_level", 32'(level), 15);
        chk("full_rw_ovf", 32'(ovf), 1);
        rd_ack = 1'b0;
        tick();
        chk("full_refill_level", 32'(level), 16);
        wr_req = 1'b0;

        // ---------------- 5: flush at level 7 ----------------
        rd_ack = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        rd_ack = 1'b0;
        chk("pre_flush_level", 32'(level), 7);
        flush   = 1'b1;
        wr_req  = 1'b1;
        wr_data = 8'h77;
        rd_ack  = 1'b1;
        tick();
        flush  = 1'b0;
        wr_req = 1'b0;
        rd_ack = 1'b0;
        chk("flush_level", 32'(level), 0);
        chk("flush_rd_req", 32'(rd_req), 0);
        chk("flush_ovf", 32'(ovf), 1);
        tick();
        chk("flush_ovf_hold", 32'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("flush_ovf_clr", 32'(ovf), 0);

        // ---------------- 6: async reset mid-stream ----------------
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'(8'hC0 + i);
            tick();
        end
        rd_ack  = 1'b1;
        wr_data = 8'hC3;
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("arst_rd_req", 32'(rd_req), 0);
        chk("arst_wr_ack", 32'(wr_ack), 1);
        chk("arst_level", 32'(level), 0);
        wr_req = 1'b0;
        rd_ack = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        wr_req  = 1'b1;
        v       = 8'h5A;
        wr_data = v;
        tick();
        wr_req = 1'b0;
        chk("post_rst_rd_req", 32'(rd_req), 1);
        chk("post_rst_data", 32'(rd_data), 32'h5A);
        chk("post_rst_level", 32'(level), 1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_hs_sync.md
# fifo_hs_sync

Single-clock, parametrised-depth synchronous FIFO with a req/ack handshake on both its write and read sides. It is the next generation of the team's `fifo_if`-based buffering.

- Write side acts as the write slave: it consumes `data`/`req` and produces `ack`.
- Read side acts as the read slave: it produces `data`/`req` and consumes `ack`.
- Adds level reporting, programmable almost-full/almost-empty flags, synchronous flush and a sticky overflow-attempt flag.
- Sits between any two `fifo_if` endpoints in the datapath.

## Interface

Parameters:

- `dw`, 8, data width in bits (≥1)
- `depth`, 16, number of entries; power of two, ≥2
- `af_thr`, `depth-2`, almost_full asserted when level ≥ af_thr (1..depth)
- `ae_thr`, 2, almost_empty asserted when level ≤ ae_thr (0..depth-1)

Ports (`aw = $clog2(depth)`):

- `clk`  input  1  single clock, all logic on rising edge
- `rstn`  input  1  asynchronous active-low reset
- `wr_data`  input  dw  write data
- `wr_req`  input  1  writer offers `wr_data`
- `wr_ack`  output  1  FIFO can accept; equals !full
- `rd_data`  output  dw  head-of-queue data
- `rd_req`  output  1  head valid; equals !empty
- `rd_ack`  input  1  reader takes head
- `flush`  input  1  synchronous clear
- `level`  output  aw+1  current occupancy, 0..depth
- `almost_full`  output  1  level ≥ af_thr
- `almost_empty`  output  1  level ≤ ae_thr
- `ovf`  output  1  sticky: wr_req seen while full
- `ovf_clr`  input  1  clears `ovf`

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation

Storage and pointers:

- Storage is a `depth`×`dw` register array.
- `wr_ptr` and `rd_ptr` are aw+1 bits wide; the MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (low aw bits equal) && (MSBs differ).
- `level` = wr_ptr − rd_ptr, modulo 2^(aw+1).

Transfers:

- Write transfer (`wr_xfer`) = wr_req && wr_ack. On the edge, mem[wr_ptr[aw-1:0]] ← wr_data and wr_ptr increments.
- Read transfer (`rd_xfer`) = rd_req && rd_ack. On the edge, rd_ptr increments.
- `rd_data` is a combinational read of mem[rd_ptr[aw-1:0]] (show-ahead). It holds stable while rd_req=1 and no rd_xfer occurs.
- `rd_data` is don't-care while rd_req=0; the bench must not check it then.

Handshake rules:

- `wr_ack`, `rd_req`, `level`, `almost_full` and `almost_empty` are derived from registered pointers only. They never depend combinationally on `wr_req` or `rd_ack`.
- A requester may assert req before ack. Once asserted, req and its data stay stable until a transfer occurs.

Boundary conditions:

- Simultaneous `wr_xfer` and `rd_xfer` in the same cycle: both happen and `level` is unchanged. This is legal at any non-full, non-empty level.
- When full, `wr_ack`=0, so a same-cycle read does not open a write slot. A write can happen the following cycle.
- When empty, `rd_req`=0 and there is no write-to-read bypass.
- Pointers wrap naturally through their MSB. No special case at `depth`.

Flush and overflow:

- `flush`=1 sets both pointers to 0 on the next edge. It dominates any same-cycle wr_xfer or rd_xfer; those transfers are discarded. Memory contents are not cleared.
- `ovf` sets on the edge after any cycle with wr_req=1 && full=1, and stays set.
- `ovf_clr`=1 clears `ovf`. If set and clear occur in the same cycle, set wins. `flush` does not clear `ovf`.

## Timing

Reset values (asynchronous, while rstn=0):

- pointers = 0, `level` = 0, `rd_req` = 0, `wr_ack` = 1, `ovf` = 0
- `almost_empty` = 1; `almost_full` = 0 unless af_thr = 0 (disallowed)
- Memory is not reset.
- Reset mid-operation abandons all contents immediately. Outputs follow the reset values asynchronously.

Latencies:

- Write at edge k: `rd_req` rises after edge k, giving first-word latency of 1 cycle. `level` updates after edge k.
- Read at edge k: the next entry appears on `rd_data` after edge k.
- Full throughput is 1 write and 1 read per cycle.

## Test plan

1. Reset, then 16 back-to-back writes 0x01..0x10 with rd_ack=0 (depth=16):
   - `wr_ack` drops after the 16th edge; level=16, almost_full=1 from level 14.
   - A 17th wr_req sets `ovf` one cycle later.
2. Drain the full FIFO with rd_ack=1:
   - `rd_data` sequence is 0x01..0x10, one per cycle.
   - `rd_req`=0 after the 16th edge; level=0; almost_empty=1 from level 2.
3. Continuous streaming: wr_req=rd_ack=1 for 100 cycles at level 5:
   - level stays 5 throughout; the output order matches the input order.
   - Both pointers wrap at least 6 times with no loss.
4. Full plus simultaneous read at level 16 with wr_req=1, rd_ack=1:
   - Only the read occurs that cycle; level becomes 15.
   - The write is accepted the next cycle and level returns to 16.
5. Flush: at level 7, assert flush together with wr_req and rd_ack:
   - level=0 and rd_req=0 after the edge.
   - A previously set `ovf` stays 1 until ovf_clr.
6. Asynchronous reset: drop rstn mid-stream between edges:
   - `rd_req`=0, `wr_ack`=1, level=0 immediately.
   - After release, the first write appears on `rd_data` one cycle later.
